// File: rtl/priority_encoder_83_pkg.sv
// Shared constants, FSM state type and mask helper for the 8-to-3 request encoder.
package enc_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // One-hot mask selecting a single request bit by index.
    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/priority_encoder_83_if.sv
// Request/handshake bundle between event sources, the encoder and its consumer.
interface priority_encoder_83_if;
    import enc_pkg::*;

    logic             en;
    logic [N-1:0]     in;
    logic             ack;
    logic [IDX_W-1:0] out;
    logic             valid;
    logic [N-1:0]     pend;

    modport master (
        output en, in, ack,
        input  out, valid, pend
    );

    modport slave (
        input  en, in, ack,
        output out, valid, pend
    );

endinterface

// File: rtl/priority_encoder_83_prio_enc8.sv
// Bare combinational 8-bit priority encoder; LOW_FIRST selects which end wins.
module prio_enc8 import enc_pkg::*; #(
    parameter bit LOW_FIRST = 1'b0
) (
    input  logic [N-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Later hits in the scan overwrite earlier ones, so the scan ends on the winner.
    function automatic logic [IDX_W-1:0] win_index(input logic [N-1:0] v, input bit low_first);
        logic [IDX_W-1:0] r;
        r = {IDX_W{1'b0}};
        if (low_first) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (v[i]) r = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (v[i]) r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    // Index of the winning request and whether any request exists.
    always_comb begin
        idx_o = win_index(vec_i, LOW_FIRST);
        any_o = |vec_i;
    end

endmodule

// File: rtl/priority_encoder_83.sv
// Latches request pulses and presents one pending index at a time under a valid/ack handshake.
module priority_encoder_83 import enc_pkg::*; #(
    parameter bit LOW_FIRST = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    priority_encoder_83_if.slave bus
);

    logic [N-1:0]     pend_q;
    logic [N-1:0]     pend_d;
    logic [N-1:0]     clr_s;
    logic [N-1:0]     set_s;
    logic [IDX_W-1:0] out_q;
    logic [IDX_W-1:0] out_d;
    logic [IDX_W-1:0] idx_s;
    logic             valid_q;
    logic             valid_d;
    logic             any_s;
    state_e           state_q;
    state_e           state_d;

    // Pending next-state: acked bit cleared, new requests OR'd in afterwards so set wins.
    always_comb begin
        clr_s = {N{1'b0}};
        set_s = {N{1'b0}};
        if (valid_q && bus.ack) begin
            clr_s = onehot(out_q);
        end else begin
            clr_s = {N{1'b0}};
        end
        if (bus.en) begin
            set_s = bus.in;
        end else begin
            set_s = {N{1'b0}};
        end
        pend_d = (pend_q & ~clr_s) | set_s;
    end

    prio_enc8 #(
        .LOW_FIRST (LOW_FIRST)
    ) u_enc (
        .vec_i (pend_d),
        .idx_o (idx_s),
        .any_o (any_s)
    );

    // Handshake FSM: out is only reloaded on entry to BUSY or on an ack.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    state_d = BUSY;
                    out_d   = idx_s;
                    valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            BUSY: begin
                if (bus.ack) begin
                    if (any_s) begin
                        state_d = BUSY;
                        out_d   = idx_s;
                        valid_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end else begin
                    state_d = BUSY;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State, pending and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= {N{1'b0}};
            out_q   <= {IDX_W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;
    assign bus.pend  = pend_q;

endmodule

// File: tb/tb_priority_encoder_83.sv
// Scoreboard bench for priority_encoder_83 with one instance per priority direction.
module tb_priority_encoder_83;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // Expected {out[2:0], valid, pend[7:0]} pushed at drive time, popped after the edge.
    logic [11:0] sb [$];

    priority_encoder_83_if b0 ();
    priority_encoder_83_if b1 ();

    priority_encoder_83 #(.LOW_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    priority_encoder_83 #(.LOW_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus word: {en, in[7:0], ack, out[2:0], valid, pend[7:0]}
    function automatic logic [21:0] stp(input logic en, input logic [7:0] in, input logic ack,
                                        input logic [2:0] o, input logic v, input logic [7:0] p);
        return {en, in, ack, o, v, p};
    endfunction

    task automatic test_reset();
        logic [11:0] e;
        rst = 1'b1;
        b0.en = 1'b0; b0.in = 8'h00; b0.ack = 1'b0;
        b1.en = 1'b0; b1.in = 8'h00; b1.ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({b0.out, b0.valid, b0.pend} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state0: got out=%0d valid=%0b pend=%02h, want 0/0/00", b0.out, b0.valid, b0.pend);
        end
        n_checks++;
        if ({b1.out, b1.valid, b1.pend} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state1: got out=%0d valid=%0b pend=%02h, want 0/0/00", b1.out, b1.valid, b1.pend);
        end
        @(negedge clk);
        rst = 1'b0;
        b0.en = 1'b1; b0.in = 8'h5A;
        sb.push_back({3'd6, 1'b1, 8'h5A});
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if ({b0.out, b0.valid, b0.pend} !== e) begin
            n_fail++;
            $display("FAIL load_5a: got out=%0d valid=%0b pend=%02h, want out=%0d valid=%0b pend=%02h",
                     b0.out, b0.valid, b0.pend, e[11:9], e[8], e[7:0]);
        end
        b0.en = 1'b0; b0.in = 8'h00;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({b0.out, b0.valid, b0.pend} !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset: got out=%0d valid=%0b pend=%02h, want 0/0/00", b0.out, b0.valid, b0.pend);
        end
        @(negedge clk);
        rst = 1'b0;
        b0.en = 1'b1; b0.in = 8'h10;
        sb.push_back({3'd4, 1'b1, 8'h10});
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if ({b0.out, b0.valid, b0.pend} !== e) begin
            n_fail++;
            $display("FAIL single_req: got out=%0d valid=%0b pend=%02h, want out=%0d valid=%0b pend=%02h",
                     b0.out, b0.valid, b0.pend, e[11:9], e[8], e[7:0]);
        end
        b0.en = 1'b0; b0.in = 8'h00; b0.ack = 1'b1;
        sb.push_back({3'd4, 1'b0, 8'h00});
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if ({b0.out, b0.valid, b0.pend} !== e) begin
            n_fail++;
            $display("FAIL single_ack: got out=%0d valid=%0b pend=%02h, want out=%0d valid=%0b pend=%02h",
                     b0.out, b0.valid, b0.pend, e[11:9], e[8], e[7:0]);
        end
        b0.ack = 1'b0;
    endtask

    task automatic test_drain();
        logic [21:0] st [5];
        logic [11:0] e;
        st[0] = stp(1'b1, 8'h85, 1'b0, 3'd7, 1'b1, 8'h85);
        st[1] = stp(1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'h05);
        st[2] = stp(1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 8'h01);
        st[3] = stp(1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00);
        st[4] = stp(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            b0.en = st[k][21]; b0.in = st[k][20:13]; b0.ack = st[k][12];
            sb.push_back(st[k][11:0]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if ({b0.out, b0.valid, b0.pend} !== e) begin
                n_fail++;
                $display("FAIL drain[%0d]: got out=%0d valid=%0b pend=%02h, want out=%0d valid=%0b pend=%02h",
                         k, b0.out, b0.valid, b0.pend, e[11:9], e[8], e[7:0]);
            end
        end
    endtask

    task automatic test_lock();
        logic [21:0] st [5];
        logic [11:0] e;
        st[0] = stp(1'b1, 8'h02, 1'b0, 3'd1, 1'b1, 8'h02);
        st[1] = stp(1'b1, 8'h40, 1'b0, 3'd1, 1'b1, 8'h42);
        st[2] = stp(1'b0, 8'h00, 1'b1, 3'd6, 1'b1, 8'h40);
        st[3] = stp(1'b0, 8'h00, 1'b1, 3'd6, 1'b0, 8'h00);
        st[4] = stp(1'b0, 8'h00, 1'b0, 3'd6, 1'b0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            b0.en = st[k][21]; b0.in = st[k][20:13]; b0.ack = st[k][12];
            sb.push_back(st[k][11:0]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if ({b0.out, b0.valid, b0.pend} !== e) begin
                n_fail++;
                $display("FAIL lock[%0d]: got out=%0d valid=%0b pend=%02h, want out=%0d valid=%0b pend=%02h",
                         k, b0.out, b0.valid, b0.pend, e[11:9], e[8], e[7:0]);
            end
        end
    endtask

    task automatic test_set_beats_clear();
        logic [21:0] st [4];
        logic [11:0] e;
        st[0] = stp(1'b1, 8'h08, 1'b0, 3'd3, 1'b1, 8'h08);
        st[1] = stp(1'b1, 8'h08, 1'b1, 3'd3, 1'b1, 8'h08);
        st[2] = stp(1'b0, 8'h00, 1'b1, 3'd3, 1'b0, 8'h00);
        st[3] = stp(1'b0, 8'h00, 1'b0, 3'd3, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            b0.en = st[k][21]; b0.in = st[k][20:13]; b0.ack = st[k][12];
            sb.push_back(st[k][11:0]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if ({b0.out, b0.valid, b0.pend} !== e) begin
                n_fail++;
                $display("FAIL set_clr[%0d]: got out=%0d valid=%0b pend=%02h, want out=%0d valid=%0b pend=%02h",
                         k, b0.out, b0.valid, b0.pend, e[11:9], e[8], e[7:0]);
            end
        end
    endtask

    task automatic test_relatch();
        logic [21:0] st [5];
        logic [11:0] e;
        st[0] = stp(1'b1, 8'h20, 1'b0, 3'd5, 1'b1, 8'h20);
        st[1] = stp(1'b1, 8'h20, 1'b0, 3'd5, 1'b1, 8'h20);
        st[2] = stp(1'b1, 8'h20, 1'b1, 3'd5, 1'b1, 8'h20);
        st[3] = stp(1'b1, 8'h00, 1'b1, 3'd5, 1'b0, 8'h00);
        st[4] = stp(1'b0, 8'h00, 1'b0, 3'd5, 1'b0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            b0.en = st[k][21]; b0.in = st[k][20:13]; b0.ack = st[k][12];
            sb.push_back(st[k][11:0]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if ({b0.out, b0.valid, b0.pend} !== e) begin
                n_fail++;
                $display("FAIL relatch[%0d]: got out=%0d valid=%0b pend=%02h, want out=%0d valid=%0b pend=%02h",
                         k, b0.out, b0.valid, b0.pend, e[11:9], e[8], e[7:0]);
            end
        end
    endtask

    task automatic test_enable_gating();
        logic [21:0] st [9];
        logic [11:0] e;
        for (int k = 0; k < 5; k++) st[k] = stp(1'b0, 8'hFF, 1'b0, 3'd5, 1'b0, 8'h00);
        st[5] = stp(1'b1, 8'h03, 1'b0, 3'd1, 1'b1, 8'h03);
        st[6] = stp(1'b0, 8'hFF, 1'b1, 3'd0, 1'b1, 8'h01);
        st[7] = stp(1'b0, 8'hFF, 1'b1, 3'd0, 1'b0, 8'h00);
        st[8] = stp(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00);
        for (int k = 0; k < 9; k++) begin
            b0.en = st[k][21]; b0.in = st[k][20:13]; b0.ack = st[k][12];
            sb.push_back(st[k][11:0]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if ({b0.out, b0.valid, b0.pend} !== e) begin
                n_fail++;
                $display("FAIL en_gate[%0d]: got out=%0d valid=%0b pend=%02h, want out=%0d valid=%0b pend=%02h",
                         k, b0.out, b0.valid, b0.pend, e[11:9], e[8], e[7:0]);
            end
        end
    endtask

    task automatic test_low_first();
        logic [21:0] st [7];
        logic [11:0] e;
        st[0] = stp(1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00);
        st[1] = stp(1'b1, 8'h85, 1'b0, 3'd0, 1'b1, 8'h85);
        st[2] = stp(1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'h84);
        st[3] = stp(1'b0, 8'h00, 1'b1, 3'd7, 1'b1, 8'h80);
        st[4] = stp(1'b0, 8'h00, 1'b1, 3'd7, 1'b0, 8'h00);
        st[5] = stp(1'b0, 8'h00, 1'b1, 3'd7, 1'b0, 8'h00);
        st[6] = stp(1'b0, 8'h00, 1'b0, 3'd7, 1'b0, 8'h00);
        for (int k = 0; k < 7; k++) begin
            b1.en = st[k][21]; b1.in = st[k][20:13]; b1.ack = st[k][12];
            sb.push_back(st[k][11:0]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if ({b1.out, b1.valid, b1.pend} !== e) begin
                n_fail++;
                $display("FAIL low_first[%0d]: got out=%0d valid=%0b pend=%02h, want out=%0d valid=%0b pend=%02h",
                         k, b1.out, b1.valid, b1.pend, e[11:9], e[8], e[7:0]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_drain();
        test_lock();
        test_set_beats_clear();
        test_relatch();
        test_enable_gating();
        test_low_first();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d leftover entries, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_encoder_83.md
# priority_encoder_83

Sequential 8-to-3 priority encoder with request latching and a valid/ack handshake; the encode-side counterpart to the team's 3-to-8 decoder. Request pulses on `in` are captured into a pending register. The block presents the index of the highest-priority pending request on `out` and holds it stable until the consumer acknowledges it. It sits between scattered event sources and a single consumer that services one indexed event at a time, for example one that feeds `decoder_38` back to select a target.

## Interface
- `LOW_FIRST`, default 0: priority direction. 0 means bit 7 is highest priority; 1 means bit 0 is highest.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  capture enable. When 0, `in` is ignored and pending bits are held.
- `in`  in  8  request lines, sampled each rising edge while `en`=1.
- `ack`  in  1  consumer acknowledge for the index currently presented.
- `out`  out  3  presented index, registered.
- `valid`  out  1  `out` holds a pending request, registered.
- `pend`  out  8  pending register, for visibility.

## Operation
- Pending update at each edge: `pend_next = (pend & ~clr) | (en ? in : 0)`.
  - `clr` is one-hot at `out` when `valid & ack`; otherwise it is 0.
  - Set wins over clear: if `in[k]` is high with `en`=1 in the same cycle `pend[k]` is acked, `pend[k]` stays 1.
- FSM has two states, IDLE and BUSY.
  - IDLE (`valid`=0): if `pend_next != 0`, go to BUSY. Load `out` with the highest-priority bit of `pend_next` and set `valid`=1. Otherwise stay in IDLE.
  - BUSY (`valid`=1): `out` is locked. A newly latched higher-priority request does not change `out` until the current index is acked.
  - On `ack` in BUSY: if `pend_next != 0`, stay in BUSY and reload `out` with the highest-priority bit of `pend_next` (back-to-back, no idle bubble). If `pend_next == 0`, go to IDLE and set `valid`=0. `out` holds its last value.
- `ack` while `valid`=0 is ignored; no state change.
- `en`=0 does not stall the handshake. Acks continue to drain pending bits.
- Requests are level-sampled. A request held high for N edges sets its bit once. If the line is still high after its ack, the bit re-latches.

## Timing
- Reset (async assert, any time, including mid-handshake): `pend`=0x00, `out`=3'd0, `valid`=0, state IDLE. Pending requests are lost.
- After reset deasserts, the first rising edge samples `in` normally.
- Capture latency: `in[k]` high at edge t (`en`=1, IDLE) gives `valid`=1, `out`=k, `pend[k]`=1 after edge t.
- Ack latency: `ack` high at edge t clears the bit after edge t. The next index, or `valid`=0, appears after the same edge t.
- Maximum throughput is one acked index per cycle while `ack` is held high.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `enc_pkg`:
  - `N`=8 and `IDX_W`=3 constants.
  - State typedef for {IDLE, BUSY}.
- Sub-module `prio_enc8`: purely combinational. 8-bit vector in; 3-bit index and `any` out. `LOW_FIRST` is passed through as a parameter.
  - Instanced once, on `pend_next`.
  - Reusable by other blocks that need a bare priority encoder.
- Top level holds the pending register, the clear mask, the FSM, and the `out`/`valid` registers.

## Test plan
- Reset and single request: assert `rst` mid-run with `pend`=0x5A and `valid`=1. Immediately `pend`=0x00, `valid`=0, `out`=0. After release, pulse `in`=0x10 for one cycle with `en`=1. Next cycle `valid`=1, `out`=4. `ack` -> `valid`=0, `pend`=0x00.
- Priority and drain (`LOW_FIRST`=0): one-cycle `in`=0x85, then hold `ack`=1. `out` sequence is 7, 2, 0 on consecutive cycles, then `valid`=0. `pend` goes 0x85 -> 0x05 -> 0x01 -> 0x00.
- Lock during BUSY: `in`=0x02 latched, `out`=1. Next cycle `in`=0x40 with no ack; `out` stays 1 and `pend`=0x42. `ack` -> `out`=6.
- Set-beats-clear: `out`=3 presented, `ack`=1 and `in`=0x08 in the same cycle. Required: `pend[3]` remains 1, `valid`=1, `out`=3.
- Enable gating: `en`=0, `in`=0xFF for 5 cycles. Required: `pend`=0x00, `valid`=0. Repeat with `pend`=0x03 pending and `en`=0: acks still drain it to 0x00.
- `LOW_FIRST`=1 and stray ack: `in`=0x85 latched gives `out` sequence 0, 2, 7. `ack` pulses while `valid`=0 cause no change to any output.
